// File: rtl/timer_pkg.sv
// Shared constants for the timer register block: register offsets,
// reset values and TCR field positions.
package timer_pkg;

  localparam logic [11:0] OFF_TCR   = 12'h000;
  localparam logic [11:0] OFF_TDR0  = 12'h004;
  localparam logic [11:0] OFF_TDR1  = 12'h008;
  localparam logic [11:0] OFF_TCMP0 = 12'h00C;
  localparam logic [11:0] OFF_TCMP1 = 12'h010;
  localparam logic [11:0] OFF_TIER  = 12'h014;
  localparam logic [11:0] OFF_TISR  = 12'h018;
  localparam logic [11:0] OFF_THCSR = 12'h01C;

  localparam int TCR_EN          = 0;
  localparam int TCR_DIV_EN      = 1;
  localparam int TCR_DIV_VAL_LSB = 8;
  localparam int TCR_DIV_VAL_MSB = 11;

  localparam logic [3:0] DIV_VAL_RST = 4'd1;
  localparam logic [3:0] DIV_MAX     = 4'd8;

endpackage

// File: rtl/timer_prescaler.sv
// Divides pclk down to the counter tick: every cycle, or every 2^div_val
// cycles when division is enabled. Restarts whenever the timer is stopped.
module timer_prescaler (
  input  logic       pclk,
  input  logic       prst,
  input  logic       timer_en,
  input  logic       halt,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       cnt_tick
);

  logic [7:0] psc_cnt_reg;
  logic [8:0] period_m1;
  logic       active;

  assign active    = timer_en & ~halt;
  // div_val is limited to 8 by the register block, so 2^8-1 fits in psc_cnt_reg
  assign period_m1 = 9'((9'd1 << div_val) - 9'd1);
  assign cnt_tick  = active & (~div_en | ({1'b0, psc_cnt_reg} == period_m1));

  always_ff @(posedge pclk) begin
    if (prst || !active || cnt_tick) begin
      psc_cnt_reg <= 8'd0;
    end else begin
      psc_cnt_reg <= psc_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/timer_regs.sv
// Timer register file: APB-side register decode with byte strobes, TCR
// error checking, 64-bit counter, compare interrupt and debug halt.
module timer_regs
  import timer_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int PSTRB_SIZE = DATA_SIZE / 8
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_SIZE-1:0]  wdata,
  input  logic [PSTRB_SIZE-1:0] pstrb,
  input  logic                  dbg_mode,
  output logic [DATA_SIZE-1:0]  rdata,
  output logic                  err_en,
  output logic                  tim_int
);

  localparam int CNT_W = 2 * DATA_SIZE;

  logic [11:0] offset;
  logic        sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1;
  logic        sel_tier, sel_tisr, sel_thcsr;

  logic                 timer_en_reg, div_en_reg;
  logic [3:0]           div_val_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DATA_SIZE-1:0] tcmp0_reg, tcmp1_reg;
  logic                 int_en_reg, int_st_reg, halt_req_reg;

  logic                 halt_ack, cnt_tick, cnt_match, tcr_err;
  logic [DATA_SIZE-1:0] tcr_val;
  logic [DATA_SIZE-1:0] tcr_merged, tdr0_merged, tdr1_merged;
  logic [DATA_SIZE-1:0] tcmp0_merged, tcmp1_merged;
  logic [3:0]           new_div_val;
  logic                 new_div_en;
  logic                 unused_bits;

  assign offset    = addr[11:0];
  assign sel_tcr   = (offset == OFF_TCR);
  assign sel_tdr0  = (offset == OFF_TDR0);
  assign sel_tdr1  = (offset == OFF_TDR1);
  assign sel_tcmp0 = (offset == OFF_TCMP0);
  assign sel_tcmp1 = (offset == OFF_TCMP1);
  assign sel_tier  = (offset == OFF_TIER);
  assign sel_tisr  = (offset == OFF_TISR);
  assign sel_thcsr = (offset == OFF_THCSR);

  assign halt_ack = halt_req_reg & dbg_mode;

  always_comb begin
    tcr_val = '0;
    tcr_val[TCR_EN]     = timer_en_reg;
    tcr_val[TCR_DIV_EN] = div_en_reg;
    tcr_val[TCR_DIV_VAL_MSB:TCR_DIV_VAL_LSB] = div_val_reg;
  end

  // Byte-lane merge of the bus write into each writable register
  generate
    for (genvar gi = 0; gi < PSTRB_SIZE; gi++) begin : g_lane
      assign tcr_merged[gi*8 +: 8]   = pstrb[gi] ? wdata[gi*8 +: 8] : tcr_val[gi*8 +: 8];
      assign tdr0_merged[gi*8 +: 8]  = pstrb[gi] ? wdata[gi*8 +: 8] : cnt_reg[gi*8 +: 8];
      assign tdr1_merged[gi*8 +: 8]  = pstrb[gi] ? wdata[gi*8 +: 8] : cnt_reg[DATA_SIZE + gi*8 +: 8];
      assign tcmp0_merged[gi*8 +: 8] = pstrb[gi] ? wdata[gi*8 +: 8] : tcmp0_reg[gi*8 +: 8];
      assign tcmp1_merged[gi*8 +: 8] = pstrb[gi] ? wdata[gi*8 +: 8] : tcmp1_reg[gi*8 +: 8];
    end
  endgenerate

  assign new_div_val = tcr_merged[TCR_DIV_VAL_MSB:TCR_DIV_VAL_LSB];
  assign new_div_en  = tcr_merged[TCR_DIV_EN];

  // Divider settings are frozen while running; an illegal write is dropped whole
  assign tcr_err = (new_div_val > DIV_MAX) ||
                   (timer_en_reg && ((new_div_en != div_en_reg) || (new_div_val != div_val_reg)));
  assign err_en  = wr_en & sel_tcr & tcr_err;

  assign unused_bits = ^{addr[ADDR_SIZE-1:12], tcr_merged[DATA_SIZE-1:TCR_DIV_VAL_MSB+1],
                         tcr_merged[TCR_DIV_VAL_LSB-1:TCR_DIV_EN+1]};

  always_ff @(posedge pclk) begin
    if (prst) begin
      timer_en_reg <= 1'b0;
      div_en_reg   <= 1'b0;
      div_val_reg  <= DIV_VAL_RST;
    end else if (wr_en && sel_tcr && !tcr_err) begin
      timer_en_reg <= tcr_merged[TCR_EN];
      div_en_reg   <= new_div_en;
      div_val_reg  <= new_div_val;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      tcmp0_reg    <= '1;
      tcmp1_reg    <= '1;
      int_en_reg   <= 1'b0;
      halt_req_reg <= 1'b0;
    end else if (wr_en) begin
      if (sel_tcmp0) tcmp0_reg <= tcmp0_merged;
      if (sel_tcmp1) tcmp1_reg <= tcmp1_merged;
      if (sel_tier && pstrb[0]) int_en_reg <= wdata[0];
      if (sel_thcsr && pstrb[0]) halt_req_reg <= wdata[0];
    end
  end

  timer_prescaler u_prescaler (
    .pclk     (pclk),
    .prst     (prst),
    .timer_en (timer_en_reg),
    .halt     (halt_ack),
    .div_en   (div_en_reg),
    .div_val  (div_val_reg),
    .cnt_tick (cnt_tick)
  );

  // Software writes to the counter take priority over the tick
  always_ff @(posedge pclk) begin
    if (prst) begin
      cnt_reg <= '0;
    end else if (wr_en && sel_tdr0) begin
      cnt_reg[DATA_SIZE-1:0] <= tdr0_merged;
    end else if (wr_en && sel_tdr1) begin
      cnt_reg[CNT_W-1:DATA_SIZE] <= tdr1_merged;
    end else if (cnt_tick) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt_match = (cnt_reg == {tcmp1_reg, tcmp0_reg});

  always_ff @(posedge pclk) begin
    if (prst) begin
      int_st_reg <= 1'b0;
    end else if (cnt_match) begin
      int_st_reg <= 1'b1;
    end else if (wr_en && sel_tisr && pstrb[0] && wdata[0]) begin
      int_st_reg <= 1'b0;
    end
  end

  assign tim_int = int_en_reg & int_st_reg;

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (offset)
        OFF_TCR:   rdata = tcr_val;
        OFF_TDR0:  rdata = cnt_reg[DATA_SIZE-1:0];
        OFF_TDR1:  rdata = cnt_reg[CNT_W-1:DATA_SIZE];
        OFF_TCMP0: rdata = tcmp0_reg;
        OFF_TCMP1: rdata = tcmp1_reg;
        OFF_TIER:  rdata = {{(DATA_SIZE-1){1'b0}}, int_en_reg};
        OFF_TISR:  rdata = {{(DATA_SIZE-1){1'b0}}, int_st_reg};
        OFF_THCSR: rdata = {{(DATA_SIZE-2){1'b0}}, halt_ack, halt_req_reg};
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_regs.sv
// Directed and random bus traffic against timer_regs, checked every cycle
// against a transaction-level model of the register map and counter.
module tb_timer_regs;

  logic        pclk = 1'b0;
  logic        prst, wr_en, rd_en, dbg_mode;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  pstrb;
  logic        err_en, tim_int;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic        m_en, m_div_en, m_int_en, m_int_st, m_halt_req;
  logic [3:0]  m_div_val;
  logic [63:0] m_cnt, m_cmp;
  int          m_psc;

  logic [31:0] offs [10] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010,
                             32'h014, 32'h018, 32'h01C, 32'h020, 32'h7FC};

  always #5 pclk = ~pclk;

  timer_regs dut (
    .pclk     (pclk),
    .prst     (prst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .pstrb    (pstrb),
    .dbg_mode (dbg_mode),
    .rdata    (rdata),
    .err_en   (err_en),
    .tim_int  (tim_int)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_tcr();
    return {20'h0, m_div_val, 6'h0, m_div_en, m_en};
  endfunction

  function automatic bit tcr_err(input logic [31:0] v);
    return (v[11:8] > 4'd8) || (m_en && (v[1] != m_div_en || v[11:8] != m_div_val));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[11:0])
      12'h000: return m_tcr();
      12'h004: return m_cnt[31:0];
      12'h008: return m_cnt[63:32];
      12'h00C: return m_cmp[31:0];
      12'h010: return m_cmp[63:32];
      12'h014: return {31'h0, m_int_en};
      12'h018: return {31'h0, m_int_st};
      12'h01C: return {30'h0, m_halt_req & dbg_mode, m_halt_req};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_div_en = 0; m_div_val = 4'd1; m_cnt = '0; m_cmp = '1;
    m_int_en = 0; m_int_st = 0; m_halt_req = 0; m_psc = 0;
  endtask

  // One clock edge of the model, using the inputs currently on the bus
  task automatic model_edge();
    bit tick = 0, match, w1c = 0, cnt_written = 0;
    int period;
    logic [31:0] v;
    if (m_en && !(m_halt_req && dbg_mode)) begin
      period = m_div_en ? (1 << int'(m_div_val)) : 1;
      m_psc++;
      if (m_psc >= period) begin tick = 1; m_psc = 0; end
    end else begin
      m_psc = 0;
    end
    match = (m_cnt == m_cmp);
    if (wr_en) begin
      case (addr[11:0])
        12'h000: begin
          v = merge(m_tcr(), wdata, pstrb);
          if (!tcr_err(v)) begin m_en = v[0]; m_div_en = v[1]; m_div_val = v[11:8]; end
        end
        12'h004: begin m_cnt[31:0]  = merge(m_cnt[31:0], wdata, pstrb);  cnt_written = 1; end
        12'h008: begin m_cnt[63:32] = merge(m_cnt[63:32], wdata, pstrb); cnt_written = 1; end
        12'h00C: m_cmp[31:0]  = merge(m_cmp[31:0], wdata, pstrb);
        12'h010: m_cmp[63:32] = merge(m_cmp[63:32], wdata, pstrb);
        12'h014: if (pstrb[0]) m_int_en = wdata[0];
        12'h018: w1c = pstrb[0] & wdata[0];
        12'h01C: if (pstrb[0]) m_halt_req = wdata[0];
        default: ;
      endcase
    end
    if (!cnt_written && tick) m_cnt = m_cnt + 64'd1;
    if (match) m_int_st = 1;
    else if (w1c) m_int_st = 0;
  endtask

  task automatic bus(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] obs);
    bit exp_err;
    wr_en = wr; rd_en = rd; addr = a; wdata = d; pstrb = s;
    @(negedge pclk);
    exp_err = wr && (a[11:0] == 12'h000) && tcr_err(merge(m_tcr(), d, s));
    check($sformatf("err_en@%03h", a[11:0]), 64'(err_en), 64'(exp_err));
    if (rd) check($sformatf("rdata@%03h", a[11:0]), 64'(rdata), 64'(m_read(a)));
    else    check("rdata_idle", 64'(rdata), 64'h0);
    check("tim_int", 64'(tim_int), 64'(m_int_en & m_int_st));
    obs = rdata;
    if (wr) $display("[%0t] WR addr=0x%03h data=0x%08h strb=%h err=%0b", $time, a[11:0], d, s, err_en);
    if (rd) $display("[%0t] RD addr=0x%03h data=0x%08h", $time, a[11:0], rdata);
    @(posedge pclk);
    model_edge();
    #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(1'b1, 1'b0, a, d, s, dummy);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] v);
    bus(1'b0, 1'b1, a, 32'h0, 4'h0, v);
  endtask

  task automatic idle(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, dummy);
  endtask

  task automatic do_reset();
    prst = 1'b1;
    repeat (2) @(posedge pclk);
    model_reset();
    #1 prst = 1'b0;
    $display("[%0t] RESET", $time);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v, c0, c1, c2, c3, a, d;
    logic [3:0]  s;
    int op, k;
    prst = 1'b1; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; pstrb = 0; dbg_mode = 0;
    do_reset();

    // Reset values of every offset
    for (int i = 0; i < 10; i++) rd32(offs[i], v);
    rd32(32'h000, v); check("tcr_rst", 64'(v), 64'h100);
    rd32(32'h00C, v); check("tcmp0_rst", 64'(v), 64'hFFFF_FFFF);

    // Undivided counting
    wr32(32'h000, 32'h1, 4'hF);
    idle(10);
    rd32(32'h004, v); check("tdr0_run10", 64'(v >= 9 && v <= 11), 64'h1);
    rd32(32'h008, v); check("tdr1_run10", 64'(v), 64'h0);

    // Divide by 4: exactly 4 ticks over 16 cycles
    wr32(32'h000, 32'h0, 4'hF);
    wr32(32'h000, 32'h203, 4'hF);
    rd32(32'h004, c0);
    idle(15);
    rd32(32'h004, c1); check("div4_delta", 64'(c1 - c0), 64'h4);

    // Divider change while running, and out-of-range divider
    wr32(32'h000, 32'h303, 4'hF);
    rd32(32'h000, v); check("tcr_locked", 64'(v), 64'h203);
    wr32(32'h000, 32'h02, 4'h1);
    wr32(32'h000, 32'h900, 4'h2);
    rd32(32'h000, v); check("tcr_div9", 64'(v), 64'h202);

    // 64-bit wrap and compare at zero
    wr32(32'h004, 32'hFFFF_FFFE, 4'hF);
    wr32(32'h008, 32'hFFFF_FFFF, 4'hF);
    wr32(32'h00C, 32'h0, 4'hF);
    wr32(32'h010, 32'h0, 4'hF);
    wr32(32'h000, 32'h01, 4'h1);
    idle(4);
    rd32(32'h018, v); check("int_st_wrap", 64'(v), 64'h1);
    rd32(32'h008, v); check("tdr1_wrap", 64'(v), 64'h0);
    check("tim_int_masked", 64'(tim_int), 64'h0);
    wr32(32'h014, 32'h1, 4'hF);
    check("tim_int_en", 64'(tim_int), 64'h1);

    // W1C while matching keeps int_st, W1C without match clears it
    wr32(32'h000, 32'h00, 4'h1);
    wr32(32'h004, 32'h5, 4'hF);
    wr32(32'h00C, 32'h5, 4'hF);
    wr32(32'h018, 32'h1, 4'hF);
    rd32(32'h018, v); check("w1c_match", 64'(v), 64'h1);
    wr32(32'h00C, 32'h6, 4'hF);
    wr32(32'h018, 32'h1, 4'hF);
    rd32(32'h018, v); check("w1c_clear", 64'(v), 64'h0);

    // Debug halt
    wr32(32'h000, 32'h01, 4'h1);
    idle(3);
    wr32(32'h01C, 32'h1, 4'hF);
    dbg_mode = 1'b1;
    rd32(32'h01C, v); check("halt_ack", 64'(v), 64'h3);
    rd32(32'h004, c0);
    idle(20);
    rd32(32'h004, c1); check("halt_frozen", 64'(c1), 64'(c0));
    wr32(32'h004, 32'h0000_00AA, 4'h1);
    rd32(32'h004, c2); check("tdr0_byte0", 64'(c2), 64'({c0[31:8], 8'hAA}));
    dbg_mode = 1'b0;
    idle(5);
    rd32(32'h004, c3); check("halt_resume", 64'(c3 > c2), 64'h1);
    wr32(32'h01C, 32'h0, 4'hF);

    // Reset while counting
    do_reset();
    rd32(32'h004, v); check("tdr0_after_rst", 64'(v), 64'h0);
    rd32(32'h000, v); check("tcr_after_rst", 64'(v), 64'h100);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 9);
      a  = offs[k] | ($urandom() & 32'hFFFF_F000);
      s  = 4'($urandom_range(0, 15));
      d  = $urandom();
      if (k == 0) d = {20'h0, 4'($urandom_range(0, 10)), 6'h0, 2'($urandom_range(0, 3))};
      if ((k == 3 || k == 4) && $urandom_range(0, 1) == 1)
        d = (k == 3) ? m_cnt[31:0] + 32'($urandom_range(0, 20)) : m_cnt[63:32];
      if ($urandom_range(0, 15) == 0) dbg_mode = ~dbg_mode;
      if ($urandom_range(0, 199) == 0) do_reset();
      if (op < 4)      rd32(a, v);
      else if (op < 8) wr32(a, d, s);
      else             idle(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
